// File: rtl/commu_m_tp.sv
// commu_m_tp -- framed test-pattern byte source for the communication master.
//
// Produces frames of HEAD0, HEAD1, frame counter, PAYLOAD_LEN payload bytes
// and an 8-bit additive checksum. The payload pattern comes from cfg_tp[2:0].
// Bytes are presented show-ahead: tp_q holds the current byte and a tp_rd
// pulse while tp_vld is high consumes it; the next byte appears one clock later.
//
// Ports:
//   clk_sys  in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   cfg_tp   in   [7]=enable, [2:0]=pattern mode, [6:3] ignored
//   tp_rd    in   consume the byte currently on tp_q
//   tp_q     out  current pattern byte (registered)
//   tp_vld   out  tp_q holds a valid stream byte
//   tp_sof   out  tp_q holds HEAD0 (start of frame)
module commu_m_tp #(
    parameter int         PAYLOAD_LEN = 16,
    parameter logic [7:0] HEAD0       = 8'hEB,
    parameter logic [7:0] HEAD1       = 8'h90,
    parameter logic [6:0] PRBS_SEED   = 7'h7F
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic [7:0] cfg_tp,
    input  logic       tp_rd,
    output logic [7:0] tp_q,
    output logic       tp_vld,
    output logic       tp_sof
);

    typedef enum logic [2:0] {
        S_IDLE, S_HD0, S_HD1, S_CNT, S_PAY, S_SUM
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

    state_t     state_q, state_d;
    logic [2:0] mode_q, mode_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] inc_cnt_q, inc_cnt_d;
    logic [7:0] walk_q, walk_d;
    logic [6:0] lfsr_q, lfsr_d;
    logic [7:0] byte_q, byte_d;
    logic       vld_q, vld_d;
    logic       sof_q, sof_d;

    logic       adv;
    logic [7:0] cur_pay;
    logic       unused_cfg;

    assign unused_cfg = ^cfg_tp[6:3];

    // Modes 5..7 are folded onto mode 0 when latched.
    function automatic logic [2:0] norm_mode(input logic [2:0] m);
        return (m > 3'd4) ? 3'd0 : m;
    endfunction

    function automatic logic [7:0] pay_byte(input logic [2:0] m, input logic [7:0] idx,
                                            input logic [7:0] inc, input logic [6:0] lfsr,
                                            input logic [7:0] walk);
        case (m)
            3'd1:    return inc;
            3'd2:    return idx[0] ? 8'hAA : 8'h55;
            3'd3:    return {1'b0, lfsr};
            3'd4:    return walk;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        inc_cnt_d   = inc_cnt_q;
        walk_d      = walk_q;
        lfsr_d      = lfsr_q;
        adv         = tp_rd && vld_q;
        cur_pay     = pay_byte(mode_q, idx_q, inc_cnt_q, lfsr_q, walk_q);

        if (!cfg_tp[7]) begin
            // Disable drops any partial frame.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    mode_d      = norm_mode(cfg_tp[2:0]);
                    frame_cnt_d = 8'h00;
                    inc_cnt_d   = 8'h00;
                    idx_d       = 8'h00;
                    walk_d      = 8'h01;
                    lfsr_d      = PRBS_SEED;
                    state_d     = S_HD0;
                end
                S_HD0: if (adv) state_d = S_HD1;
                S_HD1: if (adv) state_d = S_CNT;
                S_CNT: if (adv) begin
                    sum_d   = frame_cnt_q;
                    idx_d   = 8'h00;
                    state_d = S_PAY;
                end
                S_PAY: if (adv) begin
                    sum_d = sum_q + cur_pay;
                    // Only the active pattern generator advances.
                    case (mode_q)
                        3'd1:    inc_cnt_d = inc_cnt_q + 8'h01;
                        3'd3:    lfsr_d    = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
                        3'd4:    walk_d    = {walk_q[6:0], walk_q[7]};
                        default: ;
                    endcase
                    if (idx_q == LAST_IDX) state_d = S_SUM;
                    else idx_d = idx_q + 8'h01;
                end
                S_SUM: if (adv) begin
                    frame_cnt_d = frame_cnt_q + 8'h01;
                    mode_d      = norm_mode(cfg_tp[2:0]);
                    state_d     = S_HD0;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Output byte is computed from the next state so tp_q is a pure register.
        case (state_d)
            S_HD0:   byte_d = HEAD0;
            S_HD1:   byte_d = HEAD1;
            S_CNT:   byte_d = frame_cnt_d;
            S_PAY:   byte_d = pay_byte(mode_d, idx_d, inc_cnt_d, lfsr_d, walk_d);
            S_SUM:   byte_d = sum_d;
            default: byte_d = 8'h00;
        endcase
        vld_d = (state_d != S_IDLE);
        sof_d = (state_d == S_HD0);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= 3'd0;
            frame_cnt_q <= 8'h00;
            sum_q       <= 8'h00;
            idx_q       <= 8'h00;
            inc_cnt_q   <= 8'h00;
            walk_q      <= 8'h01;
            lfsr_q      <= PRBS_SEED;
            byte_q      <= 8'h00;
            vld_q       <= 1'b0;
            sof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            inc_cnt_q   <= inc_cnt_d;
            walk_q      <= walk_d;
            lfsr_q      <= lfsr_d;
            byte_q      <= byte_d;
            vld_q       <= vld_d;
            sof_q       <= sof_d;
        end
    end

    assign tp_q   = byte_q;
    assign tp_vld = vld_q;
    assign tp_sof = sof_q;

endmodule

// File: tb/tb_commu_m_tp.sv
// Testbench for commu_m_tp: a stimulus process drives cfg_tp/tp_rd and a
// frame-level reference model; expected bytes are queued when a consume is
// issued and a separate monitor compares them as the DUT consumes them.
module tb_commu_m_tp;

    localparam int         PL    = 4;
    localparam logic [7:0] H0    = 8'hEB;
    localparam logic [7:0] H1    = 8'h90;
    localparam logic [6:0] SEED  = 7'h7F;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic [7:0] cfg_tp;
    logic       tp_rd;
    logic [7:0] tp_q;
    logic       tp_vld;
    logic       tp_sof;

    commu_m_tp #(.PAYLOAD_LEN(PL), .HEAD0(H0), .HEAD1(H1), .PRBS_SEED(SEED)) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .cfg_tp  (cfg_tp),
        .tp_rd   (tp_rd),
        .tp_q    (tp_q),
        .tp_vld  (tp_vld),
        .tp_sof  (tp_sof)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;

    // Reference model state: {sof, byte} entries.
    logic [8:0] fb[$];
    logic [8:0] exp_q[$];
    logic [7:0] m_fc, m_inc, m_walk;
    logic [6:0] m_lfsr;
    bit         m_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic void model_restart();
        m_fc   = 8'h00;
        m_inc  = 8'h00;
        m_walk = 8'h01;
        m_lfsr = SEED;
    endfunction

    // Builds the whole next frame from the pattern rules.
    function automatic void build_frame(input logic [2:0] mode_raw);
        logic [2:0] m;
        logic [7:0] b, s;
        m = (mode_raw > 3'd4) ? 3'd0 : mode_raw;
        fb.delete();
        fb.push_back({1'b1, H0});
        fb.push_back({1'b0, H1});
        fb.push_back({1'b0, m_fc});
        s = m_fc;
        for (int i = 0; i < PL; i++) begin
            case (m)
                3'd1: begin b = m_inc; m_inc = m_inc + 8'd1; end
                3'd2: b = (i % 2 == 1) ? 8'hAA : 8'h55;
                3'd3: begin b = {1'b0, m_lfsr}; m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]}; end
                3'd4: begin b = m_walk; m_walk = {m_walk[6:0], m_walk[7]}; end
                default: b = 8'h00;
            endcase
            s = s + b;
            fb.push_back({1'b0, b});
        end
        fb.push_back({1'b0, s});
        m_fc = m_fc + 8'd1;
    endfunction

    // One clock with tp_rd=rd; queues the expected byte when it will be consumed.
    task automatic cyc(input bit rd);
        tp_rd = rd;
        if (rd && m_en) begin
            exp_q.push_back(fb.pop_front());
            if (fb.size() == 0) build_frame(cfg_tp[2:0]);
        end
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] v);
        logic old_en;
        old_en = cfg_tp[7];
        cfg_tp = v;
        if (!v[7] && old_en) begin
            m_en = 0;
            fb.delete();
            cyc(0);
            check("disable_vld", tp_vld, 1'b0);
            check("disable_q", tp_q, 8'h00);
        end else if (v[7] && !old_en) begin
            model_restart();
            build_frame(v[2:0]);
            cyc(0);
            m_en = 1;
            check("enable_vld", tp_vld, 1'b1);
            check("enable_sof", tp_sof, 1'b1);
            check("enable_q", tp_q, H0);
        end
    endtask

    task automatic consume(input int n, input int gap_min, input int gap_max);
        for (int i = 0; i < n; i++) begin
            cyc(1);
            repeat ($urandom_range(gap_max, gap_min)) cyc(0);
        end
    endtask

    // Monitor: compares each consumed byte against the scoreboard.
    logic [7:0] prev_q;
    bit         prev_vld, prev_cons;
    always @(negedge clk_sys) begin
        if (!rst_n) begin
            prev_vld  = 0;
            prev_cons = 0;
        end else begin
            if (!tp_vld) begin
                check("idle_q", tp_q, 8'h00);
                check("idle_sof", tp_sof, 1'b0);
            end
            if (prev_vld && tp_vld && !prev_cons)
                check("hold_q", tp_q, prev_q);
            if (tp_rd && tp_vld) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_consume", 1, 0);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("tp_q", tp_q, e[7:0]);
                    check("tp_sof", tp_sof, e[8]);
                end
            end
            prev_vld  = tp_vld;
            prev_q    = tp_q;
            prev_cons = tp_rd && tp_vld;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        cfg_tp = 8'h00;
        tp_rd  = 1'b0;
        m_en   = 0;
        model_restart();
        repeat (3) @(posedge clk_sys);
        #1;
        check("reset_q", tp_q, 8'h00);
        check("reset_vld", tp_vld, 1'b0);
        check("reset_sof", tp_sof, 1'b0);
        rst_n = 1'b1;
        cyc(1);  // pulse while disabled: ignored
        cyc(0);

        // Incrementing, then alternating, then PRBS, all back-to-back reads.
        set_cfg(8'h81); consume(2 * (PL + 4), 0, 0);
        set_cfg(8'h00); set_cfg(8'h82); consume(2 * (PL + 4), 0, 0);
        set_cfg(8'h00); set_cfg(8'h83); consume(2 * (PL + 4), 0, 0);

        // Walking ones with one read every third cycle.
        set_cfg(8'h00); cyc(1); cyc(1);
        set_cfg(8'h84); consume(2 * (PL + 4), 2, 2);

        // Mode change mid-payload takes effect on the next frame.
        set_cfg(8'h00); set_cfg(8'h81); consume(5, 0, 0);
        set_cfg(8'h82); consume(PL + 4 + 3, 0, 1);

        // Disable mid-payload, stray reads, then re-enable.
        consume(5, 0, 0);
        set_cfg(8'h02); cyc(1); cyc(1); cyc(0);
        set_cfg(8'h81); consume(PL + 4, 0, 0);

        // Asynchronous reset during the payload.
        consume(5, 0, 0);
        tp_rd = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_q", tp_q, 8'h00);
        check("async_rst_vld", tp_vld, 1'b0);
        check("async_rst_sof", tp_sof, 1'b0);
        fb.delete();
        model_restart();
        @(posedge clk_sys); #1;
        rst_n = 1'b1;
        build_frame(cfg_tp[2:0]);
        cyc(0);
        check("rst_restart_sof", tp_sof, 1'b1);
        consume(2 * (PL + 4), 0, 1);

        // Randomized configuration changes and read spacing.
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(5, 0))
                0: set_cfg({1'b0, 7'($urandom)});
                1, 2: set_cfg({1'b1, 7'($urandom)});
                default: if (m_en) consume($urandom_range(20, 1), 0, $urandom_range(3, 0));
                         else begin cyc($urandom_range(1, 0) == 1); cyc(0); end
            endcase
        end

        tp_rd = 1'b0;
        cyc(0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
